// File: rtl/add_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit cfg_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && (n % stages == 0);
    endfunction

endpackage

// File: rtl/add_seg.sv
// One carry-chain segment: W-bit adder with carry-in and carry-out, purely combinational.
module add_seg #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_pipe.sv
// Pipelined N-bit add/subtract; the carry chain is cut into STAGES registered segments.
// Stream handshake: a beat moves on an edge where valid && ready; the whole pipe stalls together.
module add_pipe
    import add_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int SEG = seg_width(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_bad_cfg
        $error("add_pipe: N must be a positive multiple of STAGES");
    end

    // Stage k register holds the beat after segment k has been added.
    logic [N-1:0] pa_q [STAGES];
    logic [N-1:0] pb_q [STAGES];
    logic [N-1:0] ps_q [STAGES];
    logic         pc_q [STAGES];
    logic         pv_q [STAGES];
    logic         ovf_q;

    logic [N-1:0]   a_in    [STAGES];
    logic [N-1:0]   b_in    [STAGES];
    logic [N-1:0]   s_in    [STAGES];
    logic           c_in    [STAGES];
    logic           v_in    [STAGES];
    logic [SEG-1:0] seg_sum [STAGES];
    logic           seg_co  [STAGES];
    logic [N-1:0]   s_nxt   [STAGES];
    logic           ovf_nxt;
    logic           pipe_unused;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = (in_sub == OP_ADD) ? b : ~b;
            assign s_in[k] = '0;
            assign c_in[k] = (in_sub == OP_SUB);
            assign v_in[k] = in_valid;
        end else begin : g_next
            assign a_in[k] = pa_q[k-1];
            assign b_in[k] = pb_q[k-1];
            assign s_in[k] = ps_q[k-1];
            assign c_in[k] = pc_q[k-1];
            assign v_in[k] = pv_q[k-1];
        end

        add_seg #(.W(SEG)) u_seg (
            .a    (a_in[k][k*SEG +: SEG]),
            .b    (b_in[k][k*SEG +: SEG]),
            .cin  (c_in[k]),
            .sum  (seg_sum[k]),
            .cout (seg_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]               = s_in[k];
            s_nxt[k][k*SEG +: SEG] = seg_sum[k];
        end
        ovf_nxt = (a_in[STAGES-1][N-1] == b_in[STAGES-1][N-1]) &&
                  (s_nxt[STAGES-1][N-1] != a_in[STAGES-1][N-1]);
    end

    // Already-consumed operand bits are carried for regularity and pruned by synthesis.
    always_comb begin
        pipe_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            pipe_unused = pipe_unused ^ (^pa_q[k]) ^ (^pb_q[k]);
        end
    end

    assign in_ready = out_ready || !pv_q[STAGES-1];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < STAGES; k++) begin
                pa_q[k] <= '0;
                pb_q[k] <= '0;
                ps_q[k] <= '0;
                pc_q[k] <= 1'b0;
                pv_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (in_ready) begin
            for (int k = 0; k < STAGES; k++) begin
                pa_q[k] <= a_in[k];
                pb_q[k] <= b_in[k];
                ps_q[k] <= s_nxt[k];
                pc_q[k] <= seg_co[k];
                pv_q[k] <= v_in[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign out_valid = pv_q[STAGES-1];
    assign out_sum   = ps_q[STAGES-1];
    assign out_cout  = pc_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: three configurations (32/2, 8/1, 64/4) share one scoreboard, exercised one at a time.
module tb_add_pipe;

    logic clk;
    logic nrst_v      [3];
    logic in_valid_v  [3];
    logic in_sub_v    [3];
    logic out_ready_v [3];
    logic [63:0] a_v  [3];
    logic [63:0] b_v  [3];

    logic in_ready_v  [3];
    logic out_valid_v [3];
    logic cout_v      [3];
    logic ovf_v       [3];
    logic [63:0] sum_v [3];

    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic cout0, cout1, cout2, ovf0, ovf1, ovf2;
    logic [31:0] sum0;
    logic [7:0]  sum1;
    logic [63:0] sum2;

    int wid [3] = '{32, 8, 64};
    int tests_run;
    int tests_failed;
    logic rnd_ready;

    // Expected beats, {cout, ovf, sum zero-extended to 64}.
    logic [65:0] exp_q[$];
    logic        stalled [3] = '{1'b0, 1'b0, 1'b0};
    logic [65:0] held    [3] = '{66'd0, 66'd0, 66'd0};

    add_pipe #(.N(32), .STAGES(2)) u_dut0 (
        .clk(clk), .nreset(nrst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .in_sub(in_sub_v[0]), .a(a_v[0][31:0]), .b(b_v[0][31:0]), .out_valid(out_valid0),
        .out_ready(out_ready_v[0]), .out_sum(sum0), .out_cout(cout0), .out_ovf(ovf0)
    );

    add_pipe #(.N(8), .STAGES(1)) u_dut1 (
        .clk(clk), .nreset(nrst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .in_sub(in_sub_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out_valid(out_valid1),
        .out_ready(out_ready_v[1]), .out_sum(sum1), .out_cout(cout1), .out_ovf(ovf1)
    );

    add_pipe #(.N(64), .STAGES(4)) u_dut2 (
        .clk(clk), .nreset(nrst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
        .in_sub(in_sub_v[2]), .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid2),
        .out_ready(out_ready_v[2]), .out_sum(sum2), .out_cout(cout2), .out_ovf(ovf2)
    );

    always_comb begin
        in_ready_v[0]  = in_ready0;  in_ready_v[1]  = in_ready1;  in_ready_v[2]  = in_ready2;
        out_valid_v[0] = out_valid0; out_valid_v[1] = out_valid1; out_valid_v[2] = out_valid2;
        cout_v[0] = cout0; cout_v[1] = cout1; cout_v[2] = cout2;
        ovf_v[0]  = ovf0;  ovf_v[1]  = ovf1;  ovf_v[2]  = ovf2;
        sum_v[0]  = {32'd0, sum0};
        sum_v[1]  = {56'd0, sum1};
        sum_v[2]  = sum2;
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [65:0] model(input int n, input logic sub,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask;
        logic [63:0] sum;
        logic [64:0] u;
        logic        cout;
        logic        ovf;
        logic signed [65:0] sa, sb, r, lim;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        if (sub) begin
            sum  = (a - b) & mask;
            cout = (a >= b);
        end else begin
            u    = {1'b0, a} + {1'b0, b};
            sum  = u[63:0] & mask;
            cout = u[n];
        end
        // Signed overflow: exact signed result falls outside the n-bit range.
        lim = 66'sd1 <<< (n - 1);
        sa  = $signed({2'b00, a});
        sb  = $signed({2'b00, b});
        if (a[n-1]) sa = sa - (lim <<< 1);
        if (b[n-1]) sb = sb - (lim <<< 1);
        r   = sub ? (sa - sb) : (sa + sb);
        ovf = (r >= lim) || (r < -lim);
        return {cout, ovf, sum};
    endfunction

    function automatic logic [63:0] rand_op(input int n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        r    = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       r = mask;
            1:       r = 64'd1 << (n - 1);
            2:       r = (64'd1 << (n - 1)) - 64'd1;
            3:       r = 64'd0;
            default: r = r;
        endcase
        return r & mask;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every delivered beat, and checks outputs hold while stalled.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (!nrst_v[c]) begin
                stalled[c] = 1'b0;
            end else begin
                if (stalled[c]) begin
                    check("stall_hold", {cout_v[c], ovf_v[c], sum_v[c]}, held[c]);
                    check("stall_valid", 66'(out_valid_v[c]), 66'd1);
                end
                if (out_valid_v[c] && out_ready_v[c]) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_beat cfg%0d: got sum %h, expected no beat", c, sum_v[c]);
                    end else begin
                        check("scoreboard", {cout_v[c], ovf_v[c], sum_v[c]}, exp_q.pop_front());
                    end
                end
                stalled[c] = out_valid_v[c] && !out_ready_v[c];
                held[c]    = {cout_v[c], ovf_v[c], sum_v[c]};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) begin
            for (int c = 0; c < 3; c++) out_ready_v[c] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_exp(input int c, input logic sub, input logic [63:0] a,
                            input logic [63:0] b, input logic [65:0] exp);
        int guard;
        guard         = 0;
        in_valid_v[c] = 1'b1;
        in_sub_v[c]   = sub;
        a_v[c]        = a;
        b_v[c]        = b;
        @(negedge clk);
        while (!in_ready_v[c] && guard < 1000) begin
            tick();
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout cfg%0d: in_ready stayed 0 for %0d cycles, expected 1", c, guard);
        end else begin
            exp_q.push_back(exp);
        end
        tick();
        in_valid_v[c] = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            tick();
            guard++;
        end
        check("drain_empty", 66'(exp_q.size()), 66'd0);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic sub;
        logic [63:0] ra, rb;
        tests_run    = 0;
        tests_failed = 0;
        rnd_ready    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nrst_v[c] = 1'b0; in_valid_v[c] = 1'b0; in_sub_v[c] = 1'b0;
            a_v[c] = '0; b_v[c] = '0; out_ready_v[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("reset_sum", {2'b00, sum_v[c]}, 66'd0);
            check("reset_ctrl", 66'({out_valid_v[c], in_ready_v[c], cout_v[c], ovf_v[c]}), 66'b0100);
            nrst_v[c]      = 1'b1;
            out_ready_v[c] = 1'b1;
        end
        tick();

        // Directed corner cases, 32/2.
        send_exp(0, 1'b0, 64'hFFFF_FFFF, 64'h1, {1'b1, 1'b0, 64'h0000_0000});
        send_exp(0, 1'b1, 64'd5,         64'd7, {1'b0, 1'b0, 64'hFFFF_FFFE});
        send_exp(0, 1'b1, 64'd7,         64'd5, {1'b1, 1'b0, 64'h0000_0002});
        send_exp(0, 1'b0, 64'h7FFF_FFFF, 64'h1, {1'b0, 1'b1, 64'h8000_0000});
        send_exp(0, 1'b1, 64'h8000_0000, 64'h1, {1'b1, 1'b1, 64'h7FFF_FFFF});
        drain();

        // Back-to-back stream with downstream stalled for three cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_exp(0, 1'b0, 64'(i), 64'(i * 256), {2'b00, 64'(i * 257)});
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready_v[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 66'(in_ready_v[0]), 66'd0);
                end
                @(posedge clk);
                #1 out_ready_v[0] = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        out_ready_v[0] = 1'b0;
        send_exp(0, 1'b0, 64'd10, 64'd20, 66'd30);
        send_exp(0, 1'b0, 64'd11, 64'd21, 66'd32);
        nrst_v[0] = 1'b0;
        #1;
        check("mid_reset_sum", {2'b00, sum_v[0]}, 66'd0);
        check("mid_reset_ctrl", 66'({out_valid_v[0], in_ready_v[0], cout_v[0], ovf_v[0]}), 66'b0100);
        exp_q.delete();
        tick();
        tick();
        nrst_v[0]      = 1'b1;
        out_ready_v[0] = 1'b1;
        tick();

        // Latency of the first beat after reset.
        in_valid_v[0] = 1'b1; in_sub_v[0] = 1'b0; a_v[0] = 64'd3; b_v[0] = 64'd4;
        @(negedge clk);
        exp_q.push_back(66'd7);
        tick();
        in_valid_v[0] = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid_v[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency_after_reset", 66'(k), 66'd1);
        tick();
        drain();

        // Random operands, ops and backpressure on every configuration.
        rnd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            repeat (150) begin
                sub = 1'($urandom_range(0, 1));
                ra  = rand_op(wid[c]);
                rb  = rand_op(wid[c]);
                send_exp(c, sub, ra, rb, model(wid[c], sub, ra, rb));
                if ($urandom_range(0, 3) == 0) tick();
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        tests_failed++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
